tlb_refill_controller: RTL and testbench

Hardware TLB-miss handler shared by the instruction TLB (fetch stage) and the data TLB (memory stage). On a miss it arbitrates between the two requesters and reads the page-table entry through the memory arbiter's read port. It then writes the translation into the requesting TLB and pulses that TLB's ready flag, or raises a fault for an invalid entry. It sits beside `stall_control`. The stage that missed stays stalled until its ready flag pulses or its fault is handled.

---
 rtl/tlb_refill_if.sv | 55 +++++
 rtl/tlb_refill_controller.sv | 164 ++++++++++++++++
 tb/tb_tlb_refill_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_refill_if.sv
// Bundle between the TLB refill controller and its environment: the two
// TLB miss/refill ports plus the read port of the memory arbiter.
// master : the refill controller (drives refill strobes and memory requests)
// slave  : the TLBs and memory arbiter
interface tlb_refill_if #(
    parameter int unsigned OFFSET         = 12,
    parameter int unsigned PHYS_ADDR_SIZE = 20,
    parameter int unsigned LINE_WIDTH     = 128
);
    localparam int unsigned VPN_W = 32 - OFFSET;

    // iTLB side
    logic                      itlb_miss;
    logic [VPN_W-1:0]          itlb_vpage;
    logic [VPN_W-1:0]          itlb_w_virtual_page_i;
    logic [VPN_W-1:0]          itlb_w_phys_page_i;
    logic                      itlb_write_enable_i;
    logic                      itlb_ready;
    logic                      itlb_fault;

    // dTLB side
    logic                      dtlb_miss;
    logic [VPN_W-1:0]          dtlb_vpage;
    logic [VPN_W-1:0]          dtlb_w_virtual_page_i;
    logic [VPN_W-1:0]          dtlb_w_phys_page_i;
    logic                      dtlb_write_enable_i;
    logic                      dtlb_ready;
    logic                      dtlb_fault;

    // memory arbiter read port
    logic                      mem_enable;
    logic [PHYS_ADDR_SIZE-1:0] mem_address;
    logic [LINE_WIDTH-1:0]     mem_data;
    logic                      mem_ready;

    logic                      busy;

    modport master (
        input  itlb_miss, itlb_vpage, dtlb_miss, dtlb_vpage, mem_data, mem_ready,
        output itlb_w_virtual_page_i, itlb_w_phys_page_i, itlb_write_enable_i,
               itlb_ready, itlb_fault,
               dtlb_w_virtual_page_i, dtlb_w_phys_page_i, dtlb_write_enable_i,
               dtlb_ready, dtlb_fault,
               mem_enable, mem_address, busy
    );

    modport slave (
        output itlb_miss, itlb_vpage, dtlb_miss, dtlb_vpage, mem_data, mem_ready,
        input  itlb_w_virtual_page_i, itlb_w_phys_page_i, itlb_write_enable_i,
               itlb_ready, itlb_fault,
               dtlb_w_virtual_page_i, dtlb_w_phys_page_i, dtlb_write_enable_i,
               dtlb_ready, dtlb_fault,
               mem_enable, mem_address, busy
    );
endinterface

// File: rtl/tlb_refill_controller.sv
// Hardware TLB-miss handler shared by the iTLB and dTLB. Arbitrates misses
// (dTLB first), reads the page-table entry from a single-level table at
// PT_BASE, then installs the translation and pulses ready, or raises a
// fault held until the requester drops its miss.
// Ports:
//   clock   - rising-edge clock
//   rst     - asynchronous active-high reset
//   tlb_bus - tlb_refill_if.master: miss inputs, TLB write/ready/fault
//             outputs, memory read request/response, busy
module tlb_refill_controller #(
    parameter int unsigned             OFFSET         = 12,
    parameter int unsigned             PHYS_ADDR_SIZE = 20,
    parameter int unsigned             LINE_WIDTH     = 128,
    parameter logic [PHYS_ADDR_SIZE-1:0] PT_BASE      = 20'h08000
) (
    input  logic          clock,
    input  logic          rst,
    tlb_refill_if.master  tlb_bus
);
    localparam int unsigned VPN_W = 32 - OFFSET;
    localparam int unsigned PA_W  = PHYS_ADDR_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_e;

    state_e            state_q;
    logic              sel_d_q;      // 1: serving dTLB, 0: serving iTLB
    logic [VPN_W-1:0]  vpage_q;
    logic              mem_en_q;
    logic [PA_W-1:0]   mem_addr_q;
    logic              busy_q;
    logic              iwe_q, dwe_q;
    logic              irdy_q, drdy_q;
    logic              ifault_q, dfault_q;
    logic [VPN_W-1:0]  ivirt_q, iphys_q;
    logic [VPN_W-1:0]  dvirt_q, dphys_q;

    // Byte address of the page-table entry, wrapping modulo 2^PA_W.
    function automatic logic [PA_W-1:0] entry_addr(input logic [VPN_W-1:0] vp);
        return PT_BASE + PA_W'({vp, 2'b00});
    endfunction

    logic [1:0] wsel_c;
    logic       entry_valid_c;
    logic [VPN_W-1:0] entry_phys_c;
    logic       sel_miss_c;

    // Select the entry word inside the returned line.
    assign wsel_c        = 2'(entry_addr(vpage_q) >> 2);
    assign entry_valid_c = tlb_bus.mem_data[{wsel_c, 5'd31}];
    assign entry_phys_c  = tlb_bus.mem_data[{wsel_c, 5'd0} +: VPN_W];
    assign sel_miss_c    = sel_d_q ? tlb_bus.dtlb_miss : tlb_bus.itlb_miss;

    // Refill sequencer with registered outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_d_q    <= 1'b0;
            vpage_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            iwe_q      <= 1'b0;
            dwe_q      <= 1'b0;
            irdy_q     <= 1'b0;
            drdy_q     <= 1'b0;
            ifault_q   <= 1'b0;
            dfault_q   <= 1'b0;
            ivirt_q    <= '0;
            iphys_q    <= '0;
            dvirt_q    <= '0;
            dphys_q    <= '0;
        end else begin
            iwe_q  <= 1'b0;
            dwe_q  <= 1'b0;
            irdy_q <= 1'b0;
            drdy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // dTLB wins: the memory stage holds the older instruction.
                    if (tlb_bus.dtlb_miss) begin
                        sel_d_q    <= 1'b1;
                        vpage_q    <= tlb_bus.dtlb_vpage;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= entry_addr(tlb_bus.dtlb_vpage) & ~PA_W'(4'hF);
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
                    end else if (tlb_bus.itlb_miss) begin
                        sel_d_q    <= 1'b0;
                        vpage_q    <= tlb_bus.itlb_vpage;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= entry_addr(tlb_bus.itlb_vpage) & ~PA_W'(4'hF);
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tlb_bus.mem_ready) begin
                        mem_en_q <= 1'b0;
                        if (entry_valid_c) begin
                            if (sel_d_q) begin
                                dwe_q   <= 1'b1;
                                dvirt_q <= vpage_q;
                                dphys_q <= entry_phys_c;
                            end else begin
                                iwe_q   <= 1'b1;
                                ivirt_q <= vpage_q;
                                iphys_q <= entry_phys_c;
                            end
                            state_q <= S_WRITE;
                        end else begin
                            dfault_q <= sel_d_q;
                            ifault_q <= ~sel_d_q;
                            state_q  <= S_FAULT;
                        end
                    end
                end
                S_WRITE: begin
                    drdy_q  <= sel_d_q;
                    irdy_q  <= ~sel_d_q;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    // Fault stays up until the requester flushes its miss.
                    if (!sel_miss_c) begin
                        ifault_q <= 1'b0;
                        dfault_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    mem_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign tlb_bus.mem_enable            = mem_en_q;
    assign tlb_bus.mem_address           = mem_addr_q;
    assign tlb_bus.busy                  = busy_q;
    assign tlb_bus.itlb_write_enable_i   = iwe_q;
    assign tlb_bus.dtlb_write_enable_i   = dwe_q;
    assign tlb_bus.itlb_ready            = irdy_q;
    assign tlb_bus.dtlb_ready            = drdy_q;
    assign tlb_bus.itlb_fault            = ifault_q;
    assign tlb_bus.dtlb_fault            = dfault_q;
    assign tlb_bus.itlb_w_virtual_page_i = ivirt_q;
    assign tlb_bus.itlb_w_phys_page_i    = iphys_q;
    assign tlb_bus.dtlb_w_virtual_page_i = dvirt_q;
    assign tlb_bus.dtlb_w_phys_page_i    = dphys_q;

endmodule

// File: tb/tb_tlb_refill_controller.sv
// Bench for tlb_refill_controller: directed refills against a page-table
// memory model, a per-cycle reference model, and hand-computed literals.
module tb_tlb_refill_controller;
    localparam int PT_BASE_I = 'h08000;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    tlb_refill_if #(.OFFSET(12), .PHYS_ADDR_SIZE(20), .LINE_WIDTH(128)) bus ();
    tlb_refill_if #(.OFFSET(12), .PHYS_ADDR_SIZE(20), .LINE_WIDTH(128)) bus2 ();

    tlb_refill_controller #(.OFFSET(12), .PHYS_ADDR_SIZE(20), .LINE_WIDTH(128),
                            .PT_BASE(20'h08000)) dut (
        .clock(clock), .rst(rst), .tlb_bus(bus));

    tlb_refill_controller #(.OFFSET(12), .PHYS_ADDR_SIZE(20), .LINE_WIDTH(128),
                            .PT_BASE(20'hFFFF0)) dut2 (
        .clock(clock), .rst(rst), .tlb_bus(bus2));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- page table memory model ----------------
    logic [31:0] pt [int];

    function automatic logic [31:0] pt_word(input int a);
        return pt.exists(a) ? pt[a] : 32'h0;
    endfunction

    function automatic logic [127:0] line_of(input int a);
        return {pt_word(a + 12), pt_word(a + 8), pt_word(a + 4), pt_word(a)};
    endfunction

    int           lat = 1;
    int           req_cnt = 0;
    logic         resp_rdy = 1'b0;
    logic         force_rdy = 1'b0;
    logic [127:0] resp_data = '0;
    assign bus.mem_ready = resp_rdy | force_rdy;
    assign bus.mem_data  = resp_data;

    // Answers the lat-th cycle of each request.
    always @(negedge clock) begin
        resp_rdy = 1'b0;
        if (bus.mem_enable === 1'b1 && !rst) begin
            req_cnt++;
            if (req_cnt == lat) begin
                resp_rdy  = 1'b1;
                resp_data = line_of(int'(bus.mem_address));
            end
        end else begin
            req_cnt = 0;
        end
    end

    // ---------------- reference model ----------------
    int          e = 0;          // posedges since reset
    bit          m_active = 0;
    bit          m_sel_d = 0;
    int          m_vp = 0;
    int          m_ea = 0;
    int          m_r = -1;       // edge at which the entry arrived
    bit          m_valid = 0;
    logic [19:0] x_ivirt = '0, x_iphys = '0, x_dvirt = '0, x_dphys = '0;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            e = 0; m_active = 0; m_r = -1; m_valid = 0;
            x_ivirt = '0; x_iphys = '0; x_dvirt = '0; x_dphys = '0;
        end else begin
            e++;
            if (!m_active) begin
                if (bus.dtlb_miss || bus.itlb_miss) begin
                    m_sel_d  = bus.dtlb_miss;
                    m_vp     = m_sel_d ? int'(bus.dtlb_vpage) : int'(bus.itlb_vpage);
                    m_ea     = (PT_BASE_I + m_vp * 4) % (1 << 20);
                    m_r      = -1;
                    m_active = 1;
                end
            end else if (m_r < 0) begin
                if (bus.mem_ready) begin
                    logic [31:0] w;
                    w       = pt_word(m_ea);
                    m_r     = e;
                    m_valid = w[31];
                    if (m_valid) begin
                        if (m_sel_d) begin x_dvirt = 20'(m_vp); x_dphys = w[19:0]; end
                        else         begin x_ivirt = 20'(m_vp); x_iphys = w[19:0]; end
                    end
                end
            end else if (m_valid) begin
                if (e == m_r + 2) m_active = 0;
            end else if (!(m_sel_d ? bus.dtlb_miss : bus.itlb_miss)) begin
                m_active = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        bit en, we, rdy, flt;
        en  = m_active && m_r < 0;
        we  = m_active && m_valid && m_r >= 0 && e == m_r;
        rdy = m_active && m_valid && m_r >= 0 && e == m_r + 1;
        flt = m_active && !m_valid && m_r >= 0;
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("mem_enable", 32'(bus.mem_enable), 32'(en));
        if (en) chk("mem_address", 32'(bus.mem_address), 32'(m_ea & ~15));
        chk("itlb_we", 32'(bus.itlb_write_enable_i), 32'(we && !m_sel_d));
        chk("dtlb_we", 32'(bus.dtlb_write_enable_i), 32'(we && m_sel_d));
        chk("itlb_ready", 32'(bus.itlb_ready), 32'(rdy && !m_sel_d));
        chk("dtlb_ready", 32'(bus.dtlb_ready), 32'(rdy && m_sel_d));
        chk("itlb_fault", 32'(bus.itlb_fault), 32'(flt && !m_sel_d));
        chk("dtlb_fault", 32'(bus.dtlb_fault), 32'(flt && m_sel_d));
        chk("itlb_virt", 32'(bus.itlb_w_virtual_page_i), 32'(x_ivirt));
        chk("itlb_phys", 32'(bus.itlb_w_phys_page_i), 32'(x_iphys));
        chk("dtlb_virt", 32'(bus.dtlb_w_virtual_page_i), 32'(x_dvirt));
        chk("dtlb_phys", 32'(bus.dtlb_w_phys_page_i), 32'(x_dphys));
    end

    // ---------------- directed stimulus ----------------
    // One refill with hand-computed literal expectations.
    task automatic refill(input bit is_d, input logic [19:0] vp, input int l,
                          input logic [19:0] exp_line, input logic [19:0] exp_phys,
                          input bit valid);
        @(negedge clock);
        lat = l;
        if (is_d) begin bus.dtlb_miss = 1'b1; bus.dtlb_vpage = vp; end
        else      begin bus.itlb_miss = 1'b1; bus.itlb_vpage = vp; end
        @(posedge clock);                    // edge 0: miss sampled
        @(negedge clock);
        chk("lit_mem_enable", 32'(bus.mem_enable), 32'd1);
        chk("lit_mem_address", 32'(bus.mem_address), 32'(exp_line));
        repeat (l) @(posedge clock);         // edge L: entry arrives
        @(negedge clock);
        if (valid) begin
            chk("lit_we", 32'(is_d ? bus.dtlb_write_enable_i : bus.itlb_write_enable_i), 32'd1);
            chk("lit_phys", 32'(is_d ? bus.dtlb_w_phys_page_i : bus.itlb_w_phys_page_i), 32'(exp_phys));
            chk("lit_virt", 32'(is_d ? bus.dtlb_w_virtual_page_i : bus.itlb_w_virtual_page_i), 32'(vp));
            @(negedge clock);                // ready cycle
            chk("lit_ready", 32'(is_d ? bus.dtlb_ready : bus.itlb_ready), 32'd1);
            if (is_d) bus.dtlb_miss = 1'b0; else bus.itlb_miss = 1'b0;
            @(negedge clock);
            chk("lit_busy_low", 32'(bus.busy), 32'd0);
        end else begin
            chk("lit_no_we", 32'(bus.dtlb_write_enable_i | bus.itlb_write_enable_i), 32'd0);
            repeat (3) @(negedge clock);
            chk("lit_fault_held", 32'(is_d ? bus.dtlb_fault : bus.itlb_fault), 32'd1);
            if (is_d) bus.dtlb_miss = 1'b0; else bus.itlb_miss = 1'b0;
            @(negedge clock);
            chk("lit_fault_drop", 32'(is_d ? bus.dtlb_fault : bus.itlb_fault), 32'd0);
            chk("lit_idle_after_fault", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        bus.itlb_miss = 1'b0; bus.itlb_vpage = '0;
        bus.dtlb_miss = 1'b0; bus.dtlb_vpage = '0;
        bus2.itlb_miss = 1'b0; bus2.itlb_vpage = '0;
        bus2.dtlb_miss = 1'b0; bus2.dtlb_vpage = '0;
        bus2.mem_ready = 1'b0; bus2.mem_data = '0;

        pt['h0800C] = 32'h8000_0042;
        pt['h08000] = 32'h8123_4567;
        pt['h08004] = 32'h8ABC_DEF0;
        pt['h08008] = 32'h8000_1111;
        pt['h08014] = 32'h0000_1234;
        pt['h08040] = 32'h8000_0777;
        pt['h08044] = 32'h8000_0888;

        repeat (2) @(negedge clock);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("reset_mem_address", 32'(bus.mem_address), 32'd0);
        #2 rst = 1'b0;

        // iTLB refill, L=4
        refill(1'b0, 20'h00003, 4, 20'h08000, 20'h00042, 1'b1);
        // word select, L=1
        refill(1'b0, 20'h00000, 1, 20'h08000, 20'h34567, 1'b1);
        refill(1'b1, 20'h00001, 1, 20'h08000, 20'hCDEF0, 1'b1);
        refill(1'b1, 20'h00002, 1, 20'h08000, 20'h01111, 1'b1);
        // invalid entry
        refill(1'b1, 20'h00005, 2, 20'h08010, 20'h00000, 1'b0);

        // simultaneous misses, L=2: dTLB first, iTLB follows
        @(negedge clock);
        lat = 2;
        bus.dtlb_miss = 1'b1; bus.dtlb_vpage = 20'h00010;
        bus.itlb_miss = 1'b1; bus.itlb_vpage = 20'h00011;
        repeat (3) @(negedge clock);          // after edge 2
        chk("sim_dtlb_we", 32'(bus.dtlb_write_enable_i), 32'd1);
        chk("sim_dtlb_phys", 32'(bus.dtlb_w_phys_page_i), 32'h00777);
        chk("sim_itlb_we", 32'(bus.itlb_write_enable_i), 32'd0);
        @(negedge clock);                     // after edge 3
        chk("sim_dtlb_ready", 32'(bus.dtlb_ready), 32'd1);
        chk("sim_no_ireq", 32'(bus.mem_enable), 32'd0);
        bus.dtlb_miss = 1'b0;
        @(negedge clock);                     // after edge 4: IDLE
        chk("sim_idle_gap", 32'(bus.mem_enable), 32'd0);
        @(negedge clock);                     // after edge 5
        chk("sim_ireq", 32'(bus.mem_enable), 32'd1);
        repeat (2) @(negedge clock);          // after edge 7
        chk("sim_itlb_we", 32'(bus.itlb_write_enable_i), 32'd1);
        chk("sim_itlb_phys", 32'(bus.itlb_w_phys_page_i), 32'h00888);
        @(negedge clock);
        chk("sim_itlb_ready", 32'(bus.itlb_ready), 32'd1);
        bus.itlb_miss = 1'b0;
        repeat (2) @(negedge clock);

        // reset in the middle of REQ
        lat = 10;
        bus.dtlb_miss = 1'b1; bus.dtlb_vpage = 20'h00020;
        repeat (3) @(negedge clock);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_dphys", 32'(bus.dtlb_w_phys_page_i), 32'd0);
        chk("rst_iphys", 32'(bus.itlb_w_phys_page_i), 32'd0);
        bus.dtlb_miss = 1'b0;
        @(negedge clock); force_rdy = 1'b1;
        @(negedge clock); force_rdy = 1'b0;
        #2 rst = 1'b0;
        @(negedge clock); force_rdy = 1'b1;
        @(negedge clock); force_rdy = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_no_we", 32'(bus.dtlb_write_enable_i), 32'd0);
        chk("rst_stays_idle", 32'(bus.busy), 32'd0);

        // page-table address wrap on the second instance
        @(negedge clock);
        bus2.dtlb_miss = 1'b1; bus2.dtlb_vpage = 20'h00008;
        @(negedge clock);
        chk("wrap_mem_enable", 32'(bus2.mem_enable), 32'd1);
        chk("wrap_mem_address", 32'(bus2.mem_address), 32'h00010);
        bus2.mem_ready = 1'b1;
        @(negedge clock);
        bus2.mem_ready = 1'b0;
        chk("wrap_fault", 32'(bus2.dtlb_fault), 32'd1);
        bus2.dtlb_miss = 1'b0;
        repeat (2) @(negedge clock);
        chk("wrap_idle", 32'(bus2.busy), 32'd0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
